// File: rtl/vinst_queue_if.sv
// Instruction type and the push/pop handshake bundle shared by the queue,
// its producer and the downstream controller.
package vinst_pkg;
  typedef struct packed {
    logic [7:0] opcode;
    logic [4:0] vd;
    logic [4:0] vs1;
    logic [4:0] vs2;
    logic [8:0] imm;
  } sa_inst_t;
endpackage

interface vinst_queue_if;
  logic                 wvalid;
  logic                 wready;
  vinst_pkg::sa_inst_t  winst;
  vinst_pkg::sa_inst_t  inst;
  logic                 iavail;
  logic                 ird;

  // slave = queue side, master = producer/controller side
  modport slave  (input wvalid, winst, ird, output wready, inst, iavail);
  modport master (output wvalid, winst, ird, input wready, inst, iavail);
endinterface

// File: rtl/vinst_queue.sv
// Vector instruction queue: registered head plus circular RAM, valid/ready push,
// single-cycle ird pop, occupancy/almost-full/underflow/retired-count reporting.
module vinst_queue
  import vinst_pkg::*;
#(
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned AFULL_TH = DEPTH - 2,
  parameter int unsigned PCW      = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  vinst_queue_if.slave           bus,
  input  logic                   flush,
  input  logic                   clr_err,
  output logic [$clog2(DEPTH):0] count,
  output logic                   afull,
  output logic                   underflow,
  output logic [PCW-1:0]         popcnt
);

  localparam int unsigned RamDepth = DEPTH - 1;
  localparam int unsigned PtrW     = (RamDepth > 1) ? $clog2(RamDepth) : 1;
  localparam int unsigned CntW     = $clog2(DEPTH) + 1;

  localparam logic [CntW-1:0] DepthC  = CntW'(DEPTH);
  localparam logic [CntW-1:0] AfullC  = CntW'(AFULL_TH);
  localparam logic [CntW-1:0] OneC    = CntW'(1);
  localparam logic [PtrW-1:0] PtrLast = PtrW'(RamDepth - 1);

  // Explicit wrap: RamDepth is usually not a power of two.
  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrLast) ? '0 : p + PtrW'(1);
  endfunction

  sa_inst_t        ram_q [RamDepth];
  sa_inst_t        head_q, head_d;
  logic            iavail_q, iavail_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            wready_q, wready_d;
  logic            afull_q, afull_d;
  logic            underflow_q, underflow_d;
  logic [PCW-1:0]  popcnt_q, popcnt_d;
  logic            ram_we;

  logic push, pop, ram_has, bypass;

  assign push    = bus.wvalid & wready_q;
  assign pop     = bus.ird & iavail_q;
  // Head is valid whenever count is non-zero, so anything beyond one lives in RAM.
  assign ram_has = count_q > OneC;
  assign bypass  = push & (~iavail_q | (pop & ~ram_has));

  always_comb begin
    head_d      = head_q;
    iavail_d    = iavail_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
    popcnt_d    = popcnt_q;
    ram_we      = 1'b0;
    underflow_d = underflow_q;

    if (bus.ird && !iavail_q) begin
      underflow_d = 1'b1;
    end else if (clr_err) begin
      underflow_d = 1'b0;
    end

    if (flush) begin
      iavail_d = 1'b0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
      popcnt_d = '0;
    end else begin
      if (pop) begin
        popcnt_d = popcnt_q + PCW'(1);
        if (ram_has) begin
          head_d   = ram_q[rd_ptr_q];
          rd_ptr_d = ptr_inc(rd_ptr_q);
        end else if (!push) begin
          iavail_d = 1'b0;
        end
      end
      if (bypass) begin
        head_d   = bus.winst;
        iavail_d = 1'b1;
      end else if (push) begin
        ram_we   = 1'b1;
        wr_ptr_d = ptr_inc(wr_ptr_q);
      end
      count_d = count_q + CntW'(push) - CntW'(pop);
    end

    wready_d = count_d < DepthC;
    afull_d  = count_d >= AfullC;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q      <= '0;
      iavail_q    <= 1'b0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      wready_q    <= 1'b0;
      afull_q     <= 1'b0;
      underflow_q <= 1'b0;
      popcnt_q    <= '0;
    end else begin
      head_q      <= head_d;
      iavail_q    <= iavail_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      wready_q    <= wready_d;
      afull_q     <= afull_d;
      underflow_q <= underflow_d;
      popcnt_q    <= popcnt_d;
    end
  end

  // Data storage carries no reset; validity is tracked by count and pointers.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      ram_q[wr_ptr_q] <= bus.winst;
    end
  end

  assign bus.inst   = head_q;
  assign bus.iavail = iavail_q;
  assign bus.wready = wready_q;
  assign count      = count_q;
  assign afull      = afull_q;
  assign underflow  = underflow_q;
  assign popcnt     = popcnt_q;

endmodule

// File: tb/tb_vinst_queue.sv
// Directed bench for vinst_queue: a queue-based reference model checked every
// cycle, plus hand-computed literal expectations at key points.
module tb_vinst_queue;
  import vinst_pkg::*;

  localparam int DEPTH = 8;
  localparam int AFULL = 6;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        flush = 1'b0;
  logic        clr_err = 1'b0;
  logic [3:0]  count;
  logic        afull;
  logic        underflow;
  logic [15:0] popcnt;

  vinst_queue_if bus ();

  vinst_queue #(
    .DEPTH   (DEPTH),
    .AFULL_TH(AFULL),
    .PCW     (16)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .flush    (flush),
    .clr_err  (clr_err),
    .count    (count),
    .afull    (afull),
    .underflow(underflow),
    .popcnt   (popcnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  function automatic sa_inst_t mk(input logic [7:0] op);
    sa_inst_t t;
    t.opcode = op;
    t.vd     = op[4:0];
    t.vs1    = ~op[4:0];
    t.vs2    = op[6:2];
    t.imm    = {op, 1'b1};
    return t;
  endfunction

  // Reference model: a plain FIFO of instructions plus the scalar flags.
  sa_inst_t m_q[$];
  int       m_pop = 0;
  bit       m_uf = 1'b0;
  bit       m_wready = 1'b0;

  task automatic model_reset();
    m_q.delete();
    m_pop    = 0;
    m_uf     = 1'b0;
    m_wready = 1'b0;
  endtask

  task automatic model_step();
    bit push;
    bit has;
    push = bus.wvalid && m_wready;
    has  = m_q.size() > 0;
    if (bus.ird && !has) m_uf = 1'b1;
    else if (clr_err)    m_uf = 1'b0;
    if (flush) begin
      m_q.delete();
      m_pop = 0;
    end else begin
      if (bus.ird && has) begin
        void'(m_q.pop_front());
        m_pop = (m_pop + 1) % 65536;
      end
      if (push) m_q.push_back(bus.winst);
    end
    m_wready = m_q.size() < DEPTH;
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge reset);
      if (!reset) model_reset();
      else        model_step();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      chk("count", 32'(count), 32'(m_q.size()));
      chk("iavail", 32'(bus.iavail), 32'(m_q.size() > 0));
      chk("wready", 32'(bus.wready), 32'(m_wready));
      chk("afull", 32'(afull), 32'(m_q.size() >= AFULL));
      chk("underflow", 32'(underflow), 32'(m_uf));
      chk("popcnt", 32'(popcnt), 32'(m_pop));
      if (m_q.size() > 0) chk("head", 32'(bus.inst), 32'(m_q[0]));
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic push(input logic [7:0] op);
    bus.wvalid = 1'b1;
    bus.winst  = mk(op);
    tick();
    bus.wvalid = 1'b0;
  endtask

  task automatic pop();
    bus.ird = 1'b1;
    tick();
    bus.ird = 1'b0;
  endtask

  initial begin
    bus.wvalid = 1'b0;
    bus.ird    = 1'b0;
    bus.winst  = '0;
    repeat (2) tick();
    chk("rst_inst", 32'(bus.inst), 32'd0);
    chk("rst_wready", 32'(bus.wready), 32'd0);
    reset = 1'b1;
    tick();
    chk("wready_after_rst", 32'(bus.wready), 32'd1);

    // In-order push and pop of 1,2,3
    push(8'd1);
    chk("t1_iavail", 32'(bus.iavail), 32'd1);
    chk("t1_head1", 32'(bus.inst.opcode), 32'd1);
    push(8'd2);
    push(8'd3);
    chk("t1_count", 32'(count), 32'd3);
    pop();
    chk("t1_head2", 32'(bus.inst.opcode), 32'd2);
    pop();
    chk("t1_head3", 32'(bus.inst.opcode), 32'd3);
    pop();
    chk("t1_empty", 32'(bus.iavail), 32'd0);
    chk("t1_popcnt", 32'(popcnt), 32'd3);

    // Fill to full, hold a rejected push, then pop one
    for (int i = 1; i <= 8; i++) begin
      push(8'(10 + i));
      if (i == 5) chk("t2_afull_lo", 32'(afull), 32'd0);
      if (i == 6) chk("t2_afull_hi", 32'(afull), 32'd1);
    end
    chk("t2_full_wready", 32'(bus.wready), 32'd0);
    chk("t2_full_count", 32'(count), 32'd8);
    bus.wvalid = 1'b1;
    bus.winst  = mk(8'd99);
    repeat (3) tick();
    bus.wvalid = 1'b0;
    chk("t2_no_overwrite", 32'(count), 32'd8);
    chk("t2_head", 32'(bus.inst.opcode), 32'd11);
    pop();
    chk("t2_wready_back", 32'(bus.wready), 32'd1);
    chk("t2_count7", 32'(count), 32'd7);

    // Steady-state push+pop at count=4
    flush = 1'b1;
    tick();
    flush = 1'b0;
    for (int i = 0; i < 4; i++) push(8'(30 + i));
    for (int i = 0; i < 10; i++) begin
      bus.wvalid = 1'b1;
      bus.ird    = 1'b1;
      bus.winst  = mk(8'(40 + i));
      tick();
    end
    bus.wvalid = 1'b0;
    bus.ird    = 1'b0;
    chk("t3_count", 32'(count), 32'd4);
    chk("t3_popcnt", 32'(popcnt), 32'd10);
    chk("t3_head", 32'(bus.inst.opcode), 32'd46);
    repeat (4) pop();

    // Underflow with simultaneous push; clear and set-wins
    bus.ird    = 1'b1;
    bus.wvalid = 1'b1;
    bus.winst  = mk(8'd5);
    tick();
    bus.ird    = 1'b0;
    bus.wvalid = 1'b0;
    chk("t4_uf", 32'(underflow), 32'd1);
    chk("t4_count", 32'(count), 32'd1);
    chk("t4_head", 32'(bus.inst.opcode), 32'd5);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    chk("t4_clr", 32'(underflow), 32'd0);
    pop();
    bus.ird = 1'b1;
    clr_err = 1'b1;
    tick();
    bus.ird = 1'b0;
    clr_err = 1'b0;
    chk("t4_set_wins", 32'(underflow), 32'd1);

    // Flush beats simultaneous push and pop; underflow kept
    for (int i = 0; i < 5; i++) push(8'(60 + i));
    chk("t5_count5", 32'(count), 32'd5);
    flush      = 1'b1;
    bus.wvalid = 1'b1;
    bus.winst  = mk(8'd70);
    bus.ird    = 1'b1;
    tick();
    flush      = 1'b0;
    bus.wvalid = 1'b0;
    bus.ird    = 1'b0;
    chk("t5_count", 32'(count), 32'd0);
    chk("t5_iavail", 32'(bus.iavail), 32'd0);
    chk("t5_popcnt", 32'(popcnt), 32'd0);
    chk("t5_wready", 32'(bus.wready), 32'd1);
    chk("t5_uf_kept", 32'(underflow), 32'd1);

    // Asynchronous reset between edges
    for (int i = 0; i < 3; i++) push(8'(71 + i));
    @(negedge clk);
    #1 reset = 1'b0;
    #1;
    chk("t6_iavail", 32'(bus.iavail), 32'd0);
    chk("t6_count", 32'(count), 32'd0);
    chk("t6_wready", 32'(bus.wready), 32'd0);
    chk("t6_uf", 32'(underflow), 32'd0);
    chk("t6_inst", 32'(bus.inst), 32'd0);
    tick();
    reset = 1'b1;
    tick();
    push(8'd80);
    chk("t6_after", 32'(bus.inst.opcode), 32'd80);
    pop();
    tick();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
